// File: rtl/ysyx_23060025_lsu_sbuf.sv
// LSU with a posted-write store buffer: stores retire on entry and drain over AXI4-Lite AW/W/B.
// Loads use AR/R and wait while any buffered or in-flight store hits the same word.
module ysyx_23060025_lsu_sbuf #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic                exu_valid_i,
  output logic                lsu_ready_o,
  input  logic [ADDR_LEN-1:0] addr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  output logic                lsu_valid_o,
  input  logic                wbu_ready_i,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic                load_err_o,
  output logic                bus_err_o,
  output logic                sb_empty_o,
  output logic [ADDR_LEN-1:0] addr_r_addr_o,
  output logic                addr_r_valid_o,
  input  logic                addr_r_ready_i,
  output logic [2:0]          addr_r_size_o,
  input  logic [DATA_LEN-1:0] r_data_i,
  input  logic [1:0]          r_resp_i,
  input  logic                r_valid_i,
  output logic                r_ready_o,
  output logic [ADDR_LEN-1:0] addr_w_addr_o,
  output logic                addr_w_valid_o,
  output logic [2:0]          addr_w_size_o,
  input  logic                addr_w_ready_i,
  output logic [DATA_LEN-1:0] w_data_o,
  output logic [3:0]          w_strb_o,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  input  logic [1:0]          bkwd_resp_i,
  input  logic                bkwd_valid_i,
  output logic                bkwd_ready_o
);

  localparam logic [2:0] LD_LB = 3'd1, LD_LH = 3'd2, LD_LBU = 3'd4, LD_LHU = 3'd5;
  localparam logic [1:0] ST_SB = 2'd1, ST_SH = 2'd2;
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, LD_HAZ, LD_AR, LD_R, RESP} req_st_t;
  typedef enum logic [1:0] {D_IDLE, D_SEND, D_B} drn_st_t;

  typedef struct packed {
    logic [ADDR_LEN-3:0] addr;
    logic [DATA_LEN-1:0] data;
    logic [3:0]          strb;
    logic [2:0]          size;
  } sb_ent_t;

  req_st_t st, st_nxt;
  drn_st_t dst, dst_nxt;

  logic [ADDR_LEN-1:0] req_addr;
  logic [2:0]          req_ltype;
  logic                alive;

  sb_ent_t             mem [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                aw_done, w_done;

  logic accept, is_load, push, pop, sb_full, haz;
  logic aw_hs, w_hs, aw_fin, w_fin;
  sb_ent_t new_ent;
  logic [DATA_LEN-1:0] rsh, ld_ext;

  assign sb_full     = (count == CW'(SB_DEPTH));
  // alive keeps ready low through reset and rises on the first clock after release
  assign lsu_ready_o = alive & (st == IDLE) & ~sb_full;
  assign accept      = exu_valid_i & lsu_ready_o;
  assign is_load     = (load_type_i != 3'd0);
  assign push        = accept & ~is_load & (store_type_i != 2'd0);
  assign pop         = (dst == D_B) & bkwd_valid_i;
  assign sb_empty_o  = (count == '0) & (dst == D_IDLE);

  always_comb begin
    new_ent      = '0;
    new_ent.addr = addr_i[ADDR_LEN-1:2];
    new_ent.data = wdata_i << {addr_i[1:0], 3'b000};
    case (store_type_i)
      ST_SB:   begin new_ent.strb = 4'b0001 << addr_i[1:0]; new_ent.size = 3'd0; end
      ST_SH:   begin new_ent.strb = 4'b0011 << addr_i[1:0]; new_ent.size = 3'd1; end
      default: begin new_ent.strb = 4'b1111;                new_ent.size = 3'd2; end
    endcase
  end

  // The in-flight head keeps its valid bit until B, so it is covered here too
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (sb_vld[i] && (mem[i].addr == req_addr[ADDR_LEN-1:2])) haz = 1'b1;
  end

  assign rsh = r_data_i >> {req_addr[1:0], 3'b000};
  always_comb begin
    case (req_ltype)
      LD_LB:   ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      LD_LH:   ld_ext = {{16{rsh[15]}}, rsh[15:0]};
      LD_LBU:  ld_ext = {24'd0, rsh[7:0]};
      LD_LHU:  ld_ext = {16'd0, rsh[15:0]};
      default: ld_ext = rsh;
    endcase
  end

  assign addr_r_addr_o = req_addr;
  always_comb begin
    case (req_ltype)
      LD_LB, LD_LBU: addr_r_size_o = 3'd0;
      LD_LH, LD_LHU: addr_r_size_o = 3'd1;
      default:       addr_r_size_o = 3'd2;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      st         <= IDLE;
      alive      <= 1'b0;
      req_addr   <= '0;
      req_ltype  <= '0;
      wdata_o    <= '0;
      wd_o       <= 1'b0;
      wreg_o     <= '0;
      load_err_o <= 1'b0;
    end else begin
      st    <= st_nxt;
      alive <= 1'b1;
      if (accept) begin
        req_addr   <= addr_i;
        req_ltype  <= load_type_i;
        wdata_o    <= wdata_i;
        wd_o       <= wd_i;
        wreg_o     <= wreg_i;
        load_err_o <= 1'b0;
      end
      if (st == LD_R && r_valid_i) begin
        wdata_o    <= ld_ext;
        load_err_o <= |r_resp_i;
      end
    end
  end

  always_comb begin
    st_nxt         = st;
    lsu_valid_o    = 1'b0;
    addr_r_valid_o = 1'b0;
    r_ready_o      = 1'b0;
    case (st)
      IDLE:    if (accept) st_nxt = is_load ? LD_HAZ : RESP;
      LD_HAZ:  if (!haz) st_nxt = LD_AR;
      LD_AR: begin
        addr_r_valid_o = 1'b1;
        if (addr_r_ready_i) st_nxt = LD_R;
      end
      LD_R: begin
        r_ready_o = 1'b1;
        if (r_valid_i) st_nxt = RESP;
      end
      RESP: begin
        lsu_valid_o = 1'b1;
        if (wbu_ready_i) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign addr_w_addr_o = {mem[rd_ptr].addr, 2'b00};
  assign addr_w_size_o = mem[rd_ptr].size;
  assign w_data_o      = mem[rd_ptr].data;
  assign w_strb_o      = mem[rd_ptr].strb;
  assign aw_hs         = addr_w_valid_o & addr_w_ready_i;
  assign w_hs          = w_valid_o & w_ready_i;
  assign aw_fin        = aw_done | aw_hs;
  assign w_fin         = w_done | w_hs;

  always_comb begin
    dst_nxt        = dst;
    addr_w_valid_o = 1'b0;
    w_valid_o      = 1'b0;
    bkwd_ready_o   = 1'b0;
    case (dst)
      D_IDLE: if (count != '0) dst_nxt = D_SEND;
      D_SEND: begin
        addr_w_valid_o = ~aw_done;
        w_valid_o      = ~w_done;
        if (aw_fin && w_fin) dst_nxt = D_B;
      end
      D_B: begin
        bkwd_ready_o = 1'b1;
        if (bkwd_valid_i) dst_nxt = D_IDLE;
      end
      default: dst_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      dst       <= D_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sb_vld    <= '0;
      bus_err_o <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) mem[i] <= '0;
    end else begin
      dst <= dst_nxt;
      if (dst == D_SEND && aw_fin && w_fin) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (dst == D_SEND) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (push) begin
        mem[wr_ptr]    <= new_ent;
        sb_vld[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        sb_vld[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PW'(1);
        if (|bkwd_resp_i) bus_err_o <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
